// File: rtl/unsigned_seq_divider_16x8.sv
// Radix-2 restoring unsigned divider, DW-bit dividend by YW-bit divisor,
// one quotient bit per clock with valid/ready handshakes on both sides.
module unsigned_seq_divider_16x8 #(
  parameter int unsigned DW = 16,
  parameter int unsigned YW = 8,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] z,
  input  logic [YW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] q,
  output logic [YW-1:0] r,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dvd;
  logic [YW-1:0] r_rem;
  logic [YW-1:0] r_div;
  logic [DW-1:0] r_q;
  logic [YW-1:0] r_r;
  logic          r_dbz;

  logic          w_accept;
  logic          w_zero;
  logic          w_last;
  logic [YW:0]   w_rem_t;
  logic          w_ge;
  logic [YW:0]   w_rem_n;
  logic [DW-1:0] w_dvd_n;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

  assign w_accept = in_valid & in_ready;
  assign w_zero   = (y == '0);
  assign w_last   = (r_cnt == '0);

  // The stored remainder is always below the divisor, so only the
  // trial value needs the extra bit for the YW+1-bit compare/subtract.
  assign w_rem_t = {r_rem, r_dvd[DW-1]};
  assign w_ge    = (w_rem_t >= {1'b0, r_div});
  assign w_rem_n = w_ge ? (w_rem_t - {1'b0, r_div}) : w_rem_t;
  assign w_dvd_n = {r_dvd[DW-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_zero ? DONE : BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd <= z;
            r_div <= y;
            r_rem <= '0;
            r_cnt <= CW'(DW - 1);
            r_dbz <= w_zero;
            if (w_zero) begin
              r_q <= '1;
              r_r <= z[YW-1:0];
            end
          end
        end
        BUSY: begin
          r_dvd <= w_dvd_n;
          r_rem <= w_rem_n[YW-1:0];
          if (w_last) begin
            r_q <= w_dvd_n;
            r_r <= w_rem_n[YW-1:0];
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_divider_16x8.sv
// Scoreboard bench for unsigned_seq_divider_16x8: directed cases followed by
// random operands with random handshake gaps.
module tb_unsigned_seq_divider_16x8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [7:0]  r;
  logic        div_by_zero;

  logic        dir_ready;
  logic        rnd_ready;
  logic        rnd_on;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [15:0] z;
    logic [7:0]  y;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  assign out_ready = rnd_on ? rnd_ready : dir_ready;

  unsigned_seq_divider_16x8 #(.DW(16), .YW(8), .CW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z          (z),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] zz, input logic [7:0] yy);
    exp_t e;
    e.z = zz;
    e.y = yy;
    if (yy == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = zz[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = zz / {8'd0, yy};
      e.r   = 8'(zz % {8'd0, yy});
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Inputs change only #1 after a rising edge, so the values seen on the
  // falling edge are exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(z, y));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("q", {16'd0, q}, {16'd0, e.q});
          check("r", {24'd0, r}, {24'd0, e.r});
          check("dbz", {31'd0, div_by_zero}, {31'd0, e.dbz});
          if (!e.dbz) begin
            check("inv_qyr", {16'd0, q} * {24'd0, e.y} + {24'd0, r}, {16'd0, e.z});
            check("inv_rlty", {31'd0, (r < e.y)}, 32'd1);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_on) rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] zz, input logic [7:0] yy);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    z        = zz;
    y        = yy;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        acc = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    z        = 16'($urandom);
    y        = 8'($urandom);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 300) begin
      tick();
      k++;
    end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          k;
    logic [15:0] hq;
    logic [7:0]  hr;

    n_checks  = 0;
    n_fail    = 0;
    rnd_on    = 1'b0;
    rnd_ready = 1'b0;
    dir_ready = 1'b1;
    in_valid  = 1'b0;
    z         = '0;
    y         = '0;
    rst_n     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_q", {16'd0, q}, 32'd0);
    check("rst_r", {24'd0, r}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_ir", {31'd0, in_ready}, 32'd1);

    // Basic division and latency
    issue(16'hE196, 8'hFA);
    wait_valid(k);
    check("lat_div", k, 32'd16);
    tick();
    check("ov_one_cycle", {31'd0, out_valid}, 32'd0);
    check("ir_after_out", {31'd0, in_ready}, 32'd1);

    issue(16'hFFFF, 8'h01);
    check("ir_busy", {31'd0, in_ready}, 32'd0);
    wait_valid(k);
    check("ir_done", {31'd0, in_ready}, 32'd0);
    tick();
    issue(16'h0064, 8'h07);
    wait_valid(k);
    tick();

    // Divide by zero goes straight to DONE
    issue(16'h1234, 8'h00);
    wait_valid(k);
    check("lat_dbz", k, 32'd0);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    tick();
    issue(16'h0010, 8'h04);
    check("dbz_clear", {31'd0, div_by_zero}, 32'd0);
    wait_valid(k);
    tick();

    // Backpressure with ignored in_valid pulses
    dir_ready = 1'b0;
    issue(16'h00FF, 8'hFF);
    wait_valid(k);
    hq = q;
    hr = r;
    check("bp_q", {16'd0, hq}, 32'h0001);
    check("bp_r", {24'd0, hr}, 32'h0000);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      z        = 16'h1234;
      y        = 8'h05;
      tick();
      check("bp_ov", {31'd0, out_valid}, 32'd1);
      check("bp_hold_q", {16'd0, q}, {16'd0, hq});
      check("bp_hold_r", {24'd0, r}, {24'd0, hr});
    end
    in_valid  = 1'b0;
    dir_ready = 1'b1;
    tick();
    check("bp_rel_ov", {31'd0, out_valid}, 32'd0);
    check("bp_rel_ir", {31'd0, in_ready}, 32'd1);

    // Reset mid-operation
    issue(16'hABCD, 8'h0D);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_q", {16'd0, q}, 32'd0);
    check("arst_r", {24'd0, r}, 32'd0);
    check("arst_ov", {31'd0, out_valid}, 32'd0);
    check("arst_ir", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_ov_post", {31'd0, out_valid}, 32'd0);
    issue(16'hABCD, 8'h0D);
    wait_valid(k);
    check("post_rst_lat", k, 32'd16);
    tick();

    // Random operands with random gaps and backpressure
    rnd_on = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] ry;
      repeat ($urandom_range(0, 3)) tick();
      ry = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      issue(16'($urandom), ry);
    end
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    check("sb_drain", sb.size(), 32'd0);
    rnd_on = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
